mole_round_controller: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/mole_index_picker.sv | 26 ++
 rtl/mole_round_controller.sv | 144 ++++++++++++++
 tb/tb_mole_round_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state type, widths and helpers for the whack-a-mole round controller
package game_pkg;

  localparam int NUM_LEDS = 18;
  localparam int SCORE_W  = 10;
  localparam int LEVEL_W  = 4;
  localparam int LIVES_W  = 2;
  // One extra code point so NUM_LEDS itself can mark "no previous LED".
  localparam int IDX_W    = $clog2(NUM_LEDS + 1);

  typedef enum logic [2:0] {IDLE, PICK, ON, GAP, OVER} state_t;

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_LEDS-1:0] one;
    one = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/mole_index_picker.sv
// rtl/mole_index_picker.sv - maps a raw random value onto an LED index, never repeating the previous one
module mole_index_picker
  import game_pkg::*;
#(
  parameter int RND_W = 11
) (
  input  logic [RND_W-1:0] random_value,
  input  logic [IDX_W-1:0] prev_idx,
  output logic [IDX_W-1:0] idx
);

  logic [RND_W-1:0] cand_full;
  logic [IDX_W-1:0] cand;

  always_comb begin
    cand_full = random_value % RND_W'(NUM_LEDS);
    cand      = cand_full[IDX_W-1:0];
    if (cand != prev_idx)
      idx = cand;
    else if (cand == IDX_W'(NUM_LEDS - 1))
      idx = '0;
    else
      idx = cand + IDX_W'(1);
  end

endmodule

// File: rtl/mole_round_controller.sv
// rtl/mole_round_controller.sv - round scheduler: picks the mole, times the window, judges hits, tracks score/lives/level
module mole_round_controller
  import game_pkg::*;
#(
  parameter int RND_W          = 11,
  parameter int MS_W           = 11,
  parameter int ON_MS_START    = 1000,
  parameter int ON_MS_MIN      = 300,
  parameter int ON_MS_STEP     = 100,
  parameter int GAP_MS         = 250,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LIVES      = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                ms_tick,
  input  logic [RND_W-1:0]    random_value,
  input  logic [NUM_LEDS-1:0] hit_sw,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  score,
  output logic [LIVES_W-1:0]  lives,
  output logic [LEVEL_W-1:0]  level,
  output logic                game_over,
  output logic                busy
);

  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [MS_W-1:0]    ON_START_V = MS_W'(ON_MS_START);
  localparam logic [MS_W-1:0]    ON_MIN_V   = MS_W'(ON_MS_MIN);
  localparam logic [MS_W-1:0]    ON_STEP_V  = MS_W'(ON_MS_STEP);
  localparam logic [MS_W-1:0]    GAP_LAST_V = MS_W'(GAP_MS - 1);
  localparam logic [HIT_W-1:0]   HIT_LAST_V = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [IDX_W-1:0]   NO_IDX     = IDX_W'(NUM_LEDS);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);

  state_t               state;
  logic [MS_W-1:0]      on_ms;
  logic [MS_W-1:0]      ms_cnt;
  logic [MS_W-1:0]      next_on_ms;
  logic [HIT_W-1:0]     hit_cnt;
  logic [IDX_W-1:0]     prev_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_LEDS-1:0]  hit_prev;
  logic [NUM_LEDS-1:0]  rise;
  logic                 wrong;
  logic                 good;
  logic                 on_last;

  mole_index_picker #(.RND_W(RND_W)) u_picker (
    .random_value (random_value),
    .prev_idx     (prev_idx),
    .idx          (pick_idx)
  );

  // In ON, leds is exactly the one-hot of the active index.
  always_comb begin
    rise       = hit_sw & ~hit_prev;
    wrong      = |(rise & ~leds);
    good       = |(rise & leds);
    on_last    = ms_tick && (ms_cnt == on_ms - MS_W'(1));
    next_on_ms = (on_ms >= ON_MIN_V + ON_STEP_V) ? (on_ms - ON_STEP_V) : ON_MIN_V;
  end

  assign busy      = (state == PICK) || (state == ON) || (state == GAP);
  assign game_over = (state == OVER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      leds     <= '0;
      score    <= '0;
      lives    <= '0;
      level    <= '0;
      on_ms    <= ON_START_V;
      ms_cnt   <= '0;
      hit_cnt  <= '0;
      prev_idx <= NO_IDX;
      hit_prev <= '0;
    end else begin
      hit_prev <= hit_sw;
      case (state)
        IDLE, OVER: begin
          leds <= '0;
          if (start) begin
            score    <= '0;
            lives    <= LIVES_INIT;
            level    <= '0;
            on_ms    <= ON_START_V;
            hit_cnt  <= '0;
            prev_idx <= NO_IDX;
            state    <= PICK;
          end
        end
        PICK: begin
          prev_idx <= pick_idx;
          leds     <= onehot(pick_idx);
          ms_cnt   <= '0;
          state    <= ON;
        end
        ON: begin
          // A wrong switch beats a correct one; a correct hit beats the timeout.
          if (wrong || (!good && on_last)) begin
            leds  <= '0;
            lives <= lives - LIVES_W'(1);
            if (lives == LIVES_W'(1)) begin
              state <= OVER;
            end else begin
              ms_cnt <= '0;
              state  <= GAP;
            end
          end else if (good) begin
            leds   <= '0;
            ms_cnt <= '0;
            state  <= GAP;
            if (score != '1)
              score <= score + SCORE_W'(1);
            if (hit_cnt == HIT_LAST_V) begin
              hit_cnt <= '0;
              on_ms   <= next_on_ms;
              if (level != '1)
                level <= level + LEVEL_W'(1);
            end else begin
              hit_cnt <= hit_cnt + HIT_W'(1);
            end
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        GAP: begin
          leds <= '0;
          if (ms_tick) begin
            if (ms_cnt == GAP_LAST_V)
              state <= PICK;
            else
              ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_controller.sv
// tb/tb_mole_round_controller.sv - directed bench with a behavioural game model checked every cycle
module tb_mole_round_controller;

  localparam int ON_START = 10;
  localparam int ON_MIN   = 4;
  localparam int ON_STEP  = 3;
  localparam int GAP      = 2;
  localparam int HPL      = 2;
  localparam int LIVES0   = 3;

  localparam int P_IDLE = 0, P_PICK = 1, P_ON = 2, P_GAP = 3, P_OVER = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        ms_tick = 1'b0;
  logic [10:0] random_value = 11'd40;
  logic [17:0] hit_sw = '0;
  logic [17:0] leds;
  logic [9:0]  score;
  logic [1:0]  lives;
  logic [3:0]  level;
  logic        game_over;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int div = 0;

  mole_round_controller #(
    .RND_W(11), .MS_W(11), .ON_MS_START(ON_START), .ON_MS_MIN(ON_MIN),
    .ON_MS_STEP(ON_STEP), .GAP_MS(GAP), .HITS_PER_LEVEL(HPL), .MAX_LIVES(LIVES0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ms_tick(ms_tick),
    .random_value(random_value), .hit_sw(hit_sw), .leds(leds), .score(score),
    .lives(lives), .level(level), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  // Game model: remaining-ticks countdowns and plain integers.
  int m_phase, m_score, m_lives, m_level, m_hits, m_window, m_left, m_idx, m_last;
  logic [17:0] m_prev_sw, m_rise;

  task automatic m_new_game();
    m_score = 0; m_lives = LIVES0; m_level = 0; m_hits = 0;
    m_window = ON_START; m_last = 18; m_phase = P_PICK;
  endtask

  task automatic m_miss();
    m_lives = m_lives - 1;
    m_left  = GAP;
    m_phase = (m_lives == 0) ? P_OVER : P_GAP;
  endtask

  task automatic m_hit();
    m_score = (m_score < 1023) ? m_score + 1 : 1023;
    m_hits  = m_hits + 1;
    if (m_hits == HPL) begin
      m_hits   = 0;
      m_level  = (m_level < 15) ? m_level + 1 : 15;
      m_window = (m_window - ON_STEP < ON_MIN) ? ON_MIN : m_window - ON_STEP;
    end
    m_left  = GAP;
    m_phase = P_GAP;
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase = P_IDLE; m_score = 0; m_lives = 0; m_level = 0; m_hits = 0;
      m_window = ON_START; m_left = 0; m_idx = 0; m_last = 18; m_prev_sw = '0;
    end else begin
      m_rise = hit_sw & ~m_prev_sw;
      case (m_phase)
        P_IDLE, P_OVER: if (start) m_new_game();
        P_PICK: begin
          m_idx = random_value % 18;
          if (m_idx == m_last) m_idx = (m_idx + 1) % 18;
          m_last  = m_idx;
          m_left  = m_window;
          m_phase = P_ON;
        end
        P_ON: begin
          if ((m_rise & ~(18'd1 << m_idx)) != 0) m_miss();
          else if (m_rise[m_idx]) m_hit();
          else if (ms_tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_miss();
          end
        end
        P_GAP: if (ms_tick) begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = P_PICK;
        end
        default: ;
      endcase
      m_prev_sw = hit_sw;
    end
  end

  logic [17:0] e_leds;
  logic [35:0] e_vec, a_vec;
  always @(posedge clk) begin
    #1;
    e_leds = (m_phase == P_ON) ? (18'd1 << m_idx) : 18'd0;
    e_vec  = {e_leds, 10'(m_score), 2'(m_lives), 4'(m_level),
              1'(m_phase == P_OVER), 1'(m_phase >= P_PICK && m_phase <= P_GAP)};
    a_vec  = {leds, score, lives, level, game_over, busy};
    n_cmp++;
    if (a_vec !== e_vec) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t: got leds=%h score=%0d lives=%0d level=%0d go=%b busy=%b required %h",
               $time, leds, score, lives, level, game_over, busy, e_vec);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; returns just after the rising edge that consumed them.
  task automatic cyc(input logic st, input logic [17:0] hs);
    @(negedge clk);
    start   = st;
    hit_sw  = hs;
    ms_tick = (div == 3);
    div     = (div + 1) % 4;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_lit(input string name, input logic [17:0] hs);
    for (int k = 0; k < 200 && leds == 0; k++) cyc(1'b0, hs);
    if (leds == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got leds=0 required a lit LED", name);
    end
  endtask

  task automatic wait_dark(input string name, input logic [17:0] hs, output int ticks);
    ticks = 0;
    for (int k = 0; k < 400 && leds != 0; k++) begin
      cyc(1'b0, hs);
      if (ms_tick) ticks++;
    end
    if (leds != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got leds=%h required dark", name, leds);
    end
  endtask

  task automatic do_hit();
    logic [17:0] cur;
    cur = leds;
    cyc(1'b0, cur);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    logic hitdone;

    // Reset, start, then reset again in the middle of a lit window.
    cyc(1'b0, '0); cyc(1'b0, '0);
    reset_n = 1'b1;
    cyc(1'b1, '0); cyc(1'b0, '0);
    cyc(1'b0, '0); cyc(1'b0, '0);
    reset_n = 1'b0;
    cyc(1'b0, '0); cyc(1'b0, '0);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_lives", 32'(lives), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    cyc(1'b1, '0);
    chk("pick_busy", 32'(busy), 32'd1);
    cyc(1'b0, '0);
    chk("first_led", 32'(leds), 32'h10);
    chk("start_lives", 32'(lives), 32'd3);

    // Three unanswered rounds end the game.
    wait_dark("miss1", '0, t);
    chk("window_10_ticks", t, 32'd10);
    chk("lives_after_miss1", 32'(lives), 32'd2);
    wait_lit("lit2", '0);
    chk("no_repeat_led", 32'(leds), 32'h20);
    wait_dark("miss2", '0, t);
    wait_lit("lit3", '0);
    chk("third_led", 32'(leds), 32'h10);
    wait_dark("miss3", '0, t);
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_leds", 32'(leds), 32'h0);

    // Correct hits and level-ups.
    cyc(1'b1, '0); cyc(1'b0, '0);
    do_hit();
    chk("hit1_score", 32'(score), 32'd1);
    chk("hit1_dark", 32'(leds), 32'h0);
    cyc(1'b0, '0);
    wait_lit("lit_h2", '0); do_hit(); cyc(1'b0, '0);
    chk("level1", 32'(level), 32'd1);
    for (int h = 0; h < 4; h++) begin
      wait_lit("lit_h", '0); do_hit(); cyc(1'b0, '0);
    end
    chk("level3", 32'(level), 32'd3);
    chk("score6", 32'(score), 32'd6);
    wait_lit("lit_floor", '0);
    wait_dark("floor_miss", '0, t);
    chk("window_floor_4", t, 32'd4);

    // Correct and wrong switch rising together counts as a miss.
    wait_lit("lit_wrong", '0);
    cyc(1'b0, leds | 18'h200);
    chk("wrong_lives", 32'(lives), 32'd1);
    chk("wrong_score", 32'(score), 32'd6);
    cyc(1'b0, '0);

    // Index 17 twice in a row wraps to 0; hit on the terminal tick counts.
    random_value = 11'd17;
    wait_lit("lit17", '0);
    chk("led17", 32'(leds), 32'h20000);
    do_hit(); cyc(1'b0, '0);
    wait_lit("lit_wrap", '0);
    chk("led_wrap0", 32'(leds), 32'h1);
    n = 0; hitdone = 1'b0;
    for (int k = 0; k < 200 && !hitdone && leds != 0; k++) begin
      if (n == 3 && div == 3) begin
        cyc(1'b0, 18'h1);
        hitdone = 1'b1;
      end else begin
        cyc(1'b0, '0);
        if (ms_tick) n++;
      end
    end
    chk("terminal_hit_taken", 32'(hitdone), 32'd1);
    chk("terminal_hit_score", 32'(score), 32'd8);
    chk("terminal_hit_lives", 32'(lives), 32'd1);
    chk("level4", 32'(level), 32'd4);

    // Switch held from the gap never produces a hit.
    random_value = 11'd40;
    wait_lit("lit_held", 18'h10);
    chk("held_led", 32'(leds), 32'h10);
    wait_dark("held_miss", 18'h10, t);
    chk("held_window", t, 32'd4);
    chk("held_score", 32'(score), 32'd8);
    chk("held_over", 32'(game_over), 32'd1);

    // Restart from OVER.
    cyc(1'b1, '0); cyc(1'b0, '0);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_led", 32'(leds), 32'h10);
    cyc(1'b0, '0); cyc(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
